// File: rtl/link_model_pkg.sv
// Shared constants and helpers for the lossy link model.
//   ERR_MODE_DROP / ERR_MODE_FLAG : values for the ERR_MODE parameter.
//   limit_width()                 : register width needed to hold a limiter
//                                   count up to a given maximum (min 1 bit).
// The per-stage record depends on WIDTH, so it is declared as a packed
// struct inside lossy_link_model_v2 rather than here.
package link_model_pkg;

  localparam int ERR_MODE_DROP = 0;
  localparam int ERR_MODE_FLAG = 1;

  function automatic int limit_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/link_delay_line.sv
// Fixed-latency shift pipeline with asynchronous active-low clear.
//   clk, rst_n : clock, async active-low clear of every stage
//   d          : word entering stage 0 every cycle
//   q          : word leaving the last stage (equals d when DELAY = 0)
// The line never stalls; every stage advances each cycle.
module link_delay_line #(
  parameter int WIDTH = 34,
  parameter int DELAY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DELAY == 0) begin : g_bypass
      // Zero latency: a pure wire; the clock and clear are not needed.
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stages [DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DELAY; k++) stages[k] <= '0;
        end else begin
          stages[0] <= d;
          for (int k = 1; k < DELAY; k++) stages[k] <= stages[k-1];
        end
      end

      assign q = stages[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/lossy_link_model_v2.sv
// Unidirectional, non-backpressuring lossy link model.
//   clk, rst_n      : clock, async active-low reset
//   in_valid        : sender beat valid
//   in_ready        : link accepts a beat this cycle
//   in_payload      : sender payload
//   in_error        : the beat accepted this cycle is corrupted (combinational)
//   err_req         : free input requesting corruption of this cycle's beat
//   stall_req       : free input requesting in_ready low this cycle
//   out_valid       : delivered beat valid (receiver must sink, no ready)
//   out_payload     : delivered payload
//   out_error       : delivered beat is corrupted (flag mode only)
//   cnt_accepted    : saturating count of accepted beats
//   cnt_errored     : saturating count of accepted errored beats
//
// Handshake: a beat transfers on any cycle where in_valid && in_ready are
// both high; in_ready does not depend on in_valid, and the sender may drop
// or change in_valid/in_payload freely. The output side has no ready: a beat
// is presented for exactly one cycle when out_valid is high.
module lossy_link_model_v2
  import link_model_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DELAY         = 4,
  parameter int LOSSY         = 1,
  parameter int ERR_MODE      = 0,
  parameter int MAX_ERR_BURST = 3,
  parameter int MAX_STALL     = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             in_error,
  input  logic             err_req,
  input  logic             stall_req,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_payload,
  output logic             out_error,
  output logic [CNT_W-1:0] cnt_accepted,
  output logic [CNT_W-1:0] cnt_errored
);

  localparam int STALL_W = limit_width(MAX_STALL);
  localparam int BURST_W = limit_width(MAX_ERR_BURST);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAX_STALL);
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_ERR_BURST);

  typedef struct packed {
    logic             valid;
    logic             error;
    logic [WIDTH-1:0] payload;
  } stage_t;

  logic [STALL_W-1:0] stall_run;
  logic [BURST_W-1:0] burst;
  logic               acc;
  stage_t             stage_in;
  stage_t             stage_out;

  // Limiters: once the stall run reaches its cap, ready is forced high even
  // if stall_req persists; once the errored-accept run reaches its cap,
  // corruption requests are ignored until a clean beat is accepted.
  always_comb begin
    in_ready = !stall_req || ((MAX_STALL != 0) && (stall_run == STALL_LIM));
    in_error = (LOSSY != 0) && in_ready && err_req &&
               ((MAX_ERR_BURST == 0) || (burst < BURST_LIM));
    acc      = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_run <= '0;
      burst     <= '0;
    end else begin
      // With an unbounded limit the run counters carry no meaning; pin them.
      if (MAX_STALL == 0)  stall_run <= '0;
      else if (in_ready)   stall_run <= '0;
      else                 stall_run <= stall_run + 1'b1;

      if (MAX_ERR_BURST == 0) burst <= '0;
      else if (acc)           burst <= in_error ? burst + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_accepted <= '0;
      cnt_errored  <= '0;
    end else begin
      if (acc && (cnt_accepted != '1))             cnt_accepted <= cnt_accepted + 1'b1;
      if (acc && in_error && (cnt_errored != '1))  cnt_errored  <= cnt_errored + 1'b1;
    end
  end

  // Stage 0 is loaded every cycle; non-accepted cycles become bubbles.
  assign stage_in = '{valid: acc, error: in_error && acc, payload: in_payload};

  link_delay_line #(
    .WIDTH ($bits(stage_t)),
    .DELAY (DELAY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (stage_in),
    .q     (stage_out)
  );

  always_comb begin
    out_payload = stage_out.payload;
    if (ERR_MODE == ERR_MODE_FLAG) begin
      out_valid = stage_out.valid;
      out_error = stage_out.valid && stage_out.error;
    end else begin
      out_valid = stage_out.valid && !stage_out.error;
      out_error = 1'b0;
    end
  end

  a_err_burst: assert property (@(posedge clk) disable iff (!rst_n)
    (MAX_ERR_BURST == 0) || ((burst <= BURST_LIM) && !(acc && in_error && burst >= BURST_LIM)));

  a_stall_run: assert property (@(posedge clk) disable iff (!rst_n)
    (MAX_STALL == 0) || in_ready || (stall_run < STALL_LIM));

  a_err_valid: assert property (@(posedge clk) disable iff (!rst_n)
    !out_error || out_valid);

endmodule
